// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO with storage, pointers, occupancy count,
//               almost-full/almost-empty thresholds, overflow/underflow pulses
//               and a selectable show-ahead or registered-read output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
  parameter int    DATA_SIZE  = 8,
  parameter int    ADDR_SIZE  = 4,
  parameter string SHOW_AHEAD = "ON",
  parameter int    AFULL_TH   = (1 << ADDR_SIZE) - 2,
  parameter int    AEMPTY_TH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] c_depth   = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] c_afull   = (ADDR_SIZE+1)'(AFULL_TH);
  localparam logic [ADDR_SIZE:0] c_aempty  = (ADDR_SIZE+1)'(AEMPTY_TH);

  // Parameter legality is enforced at elaboration time.
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_ctrl: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_ctrl: AEMPTY_TH must lie in 0..DEPTH-1");
  end
  if (SHOW_AHEAD != "ON" && SHOW_AHEAD != "OFF") begin : g_bad_mode
    $error("sync_fifo_ctrl: SHOW_AHEAD must be \"ON\" or \"OFF\"");
  end

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;

  // Status is decoded only from the registered count, so no request input
  // reaches an output combinationally.
  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr_en && !w_wr_acc;
      r_underflow <= rd_en && !w_rd_acc;
    end
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_afull);
  assign almost_empty = (r_count <= c_aempty);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  if (SHOW_AHEAD == "ON") begin : g_show_ahead
    // Head word is presented directly from the array while data is present.
    assign rd_data  = r_mem[r_rd_ptr];
    assign rd_valid = !w_empty;
  end else begin : g_registered
    logic [DATA_SIZE-1:0] r_rd_data;
    logic                 r_rd_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end

endmodule
`default_nettype wire
